usb_reg_master: RTL and testbench
=================================

# usb_reg_master

Bus initiator for the CW305 USB parallel register interface (usb_addr/usb_data/usb_rdn/usb_wrn/usb_cen). It turns a command handshake into byte-wide read or write bursts with parameterised setup, strobe and hold phases. It is the driving end of the protocol decoded by the register front-end, and is used as an on-FPGA self-test initiator and as the bench driver for register blocks.

## Interface
- pADDR_WIDTH, 21, width of usb_addr and cmd_addr
- pBYTECNT_SIZE, 7, width of cmd_len; bursts are 1..2^pBYTECNT_SIZE bytes
- pSETUP, 1, setup cycles per byte (≥1)
- pSTROBE, 2, strobe-low cycles per byte (≥1)
- pHOLD, 1, hold cycles per byte (≥1)
- pTIMEOUT, 255, write-data wait limit in cycles (used only with USB_REG_MASTER_TIMEOUT_EN)

- usb_clk  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  pADDR_WIDTH  first byte address
- cmd_len  in  pBYTECNT_SIZE  byte count minus 1
- wr_data  in  8  write byte
- wr_valid / wr_ready  in / out  1  write-data handshake
- rd_data  out  8  captured read byte
- rd_valid  out  1  one-cycle pulse per read byte; no backpressure
- busy  out  1  high from command accept through the last HOLD cycle
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle timeout pulse (tied 0 without the macro)
- usb_addr  out  pADDR_WIDTH  bus address
- usb_dout  out  8  bus write data
- usb_din  in  8  bus read data
- usb_isout  out  1  data-drive enable
- usb_cen, usb_rdn, usb_wrn  out  1  active-low chip enable, read strobe, write strobe

## Operation
- States: IDLE, WDATA, SETUP, STROBE, HOLD.
- IDLE: cmd_ready=1, usb_cen=usb_rdn=usb_wrn=1, usb_isout=0. On cmd_valid&cmd_ready, latch write/addr/len and reset the byte counter. Next state is WDATA for writes, SETUP for reads.
- WDATA: wr_ready=1. On wr_valid, load usb_dout and go to SETUP.
- SETUP (pSETUP cycles): usb_cen=0 and usb_addr valid; both strobes high.
- STROBE (pSTROBE cycles): usb_rdn=0 (read) or usb_wrn=0 (write).
- Reads: usb_din is sampled at the edge ending the last STROBE cycle. rd_data updates and rd_valid pulses in the first HOLD cycle.
- HOLD (pHOLD cycles): strobes high; usb_cen, usb_addr and usb_dout are held.
- After the last HOLD cycle:
  - If bytes remain: address +1 modulo 2^pADDR_WIDTH, next state WDATA or SETUP.
  - Otherwise: IDLE, with done pulsed in that IDLE cycle.
- usb_cen stays low across the whole burst, including inter-byte WDATA waits.
- usb_isout=1 for write bursts from the first WDATA through the last HOLD cycle.
- Only one strobe is ever low at a time, and a strobe is never low outside STROBE.
- Reset (async, any state): IDLE, usb_cen=usb_rdn=usb_wrn=1, usb_isout=0, usb_addr=0, usb_dout=0, rd_data=0, rd_valid=done=err=busy=0, wr_ready=0, cmd_ready=1.

## Timing
- Command accepted at edge T; for reads, SETUP begins at T+1.
- Read byte period = pSETUP+pSTROBE+pHOLD cycles (4 at defaults).
- Write byte period = same +1 WDATA cycle when wr_valid is already high; each extra cycle wr_valid is low adds one cycle.
- Read latency from accept to first rd_valid = pSETUP+pSTROBE+1 cycles.
- done and cmd_ready are high in the same cycle, so a new command can be accepted back-to-back. usb_cen returns high for at least that cycle.
- cmd_valid during busy is ignored (cmd_ready=0).

## Configuration
- USB_REG_MASTER_TIMEOUT_EN defined:
  - A counter runs while in WDATA.
  - If wr_valid is still low after pTIMEOUT cycles: err pulses, the burst is abandoned, and the FSM goes to IDLE with done also pulsed. usb_cen deasserts in that cycle.
- Undefined: WDATA waits indefinitely and err is constant 0.

## Test plan
- Read, addr 0x000010, len 0, usb_din=0xA5 during STROBE -> usb_rdn low for exactly 2 cycles, rd_data=0xA5 with rd_valid at T+4, done at T+5.
- Write, addr 0x000020, len 0, wr_data=0x3C already valid -> usb_dout=0x3C, usb_wrn low 2 cycles, usb_isout high through HOLD, usb_rdn never low.
- Read burst, addr 0x000100, len 3 -> usb_addr steps 0x100..0x103, exactly 4 rd_valid pulses, usb_cen continuously low, done once.
- Write burst, len 1, at address 0x1FFFFF, wr_valid held low 5 cycles before the second byte -> second usb_addr=0x000000 (wrap), usb_cen stays low during the stall, no strobe during WDATA.
- resetn pulsed low mid-STROBE of a write -> usb_wrn/usb_cen go high immediately and usb_isout goes 0. After release, cmd_ready=1 and a new read completes normally.
- With USB_REG_MASTER_TIMEOUT_EN and pTIMEOUT=8, write with wr_valid never asserted -> err and done pulse in the same cycle, FSM returns to IDLE. Without the macro, busy stays high.

Source files
------------

// File: rtl/usb_reg_master.sv
// usb_reg_master: bus initiator for the CW305 USB parallel register interface.
// A command (write/addr/len) becomes a byte burst. Each byte runs through
// SETUP, STROBE and HOLD phases; write bytes are first fetched in WDATA.
// usb_cen stays low for the whole burst. Strobes and enables decode directly
// from the state register, so an asynchronous reset releases the bus at once.
// Optional feature macro: USB_REG_MASTER_TIMEOUT_EN. When defined, a write
// burst whose next data byte does not arrive within pTIMEOUT cycles is
// abandoned with err and done pulsed together.
module usb_reg_master #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSETUP        = 1,
  parameter int pSTROBE       = 2,
  parameter int pHOLD         = 1,
  parameter int pTIMEOUT      = 255
) (
  input  logic                     usb_clk,
  input  logic                     resetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [pADDR_WIDTH-1:0]   cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [pADDR_WIDTH-1:0]   usb_addr,
  output logic [7:0]               usb_dout,
  input  logic [7:0]               usb_din,
  output logic                     usb_isout,
  output logic                     usb_cen,
  output logic                     usb_rdn,
  output logic                     usb_wrn
);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_STROBE, S_HOLD} state_e;

  // Phase counter counts down from (phase length - 1) to 0.
  localparam int PMAX = (pSETUP > pSTROBE) ? ((pSETUP > pHOLD) ? pSETUP : pHOLD)
                                           : ((pSTROBE > pHOLD) ? pSTROBE : pHOLD);
  localparam int PCW = $clog2(PMAX + 1);
  localparam logic [PCW-1:0] SETUP_LD  = PCW'(pSETUP - 1);
  localparam logic [PCW-1:0] STROBE_LD = PCW'(pSTROBE - 1);
  localparam logic [PCW-1:0] HOLD_LD   = PCW'(pHOLD - 1);

  state_e                   state_q, state_d;
  logic [PCW-1:0]           ph_q, ph_d;
  logic                     write_q, write_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [pBYTECNT_SIZE-1:0] len_q, len_d;
  logic [pBYTECNT_SIZE-1:0] bcnt_q, bcnt_d;
  logic [7:0]               dout_q, dout_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     done_q, done_d;
  logic                     err_d;

`ifdef USB_REG_MASTER_TIMEOUT_EN
  localparam int TCW = $clog2(pTIMEOUT + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(pTIMEOUT - 1);
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           err_q;
`endif

  // Next-state and datapath updates; all registered values default to hold.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    write_d    = write_q;
    addr_d     = addr_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef USB_REG_MASTER_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          bcnt_d  = '0;
`ifdef USB_REG_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (cmd_write) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_SETUP;
            ph_d    = SETUP_LD;
          end
        end
      end
      S_WDATA: begin
        if (wr_valid) begin
          dout_d  = wr_data;
          state_d = S_SETUP;
          ph_d    = SETUP_LD;
        end
`ifdef USB_REG_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
`endif
      end
      S_SETUP: begin
        if (ph_q == '0) begin
          state_d = S_STROBE;
          ph_d    = STROBE_LD;
        end else begin
          ph_d = ph_q - PCW'(1);
        end
      end
      S_STROBE: begin
        if (ph_q == '0) begin
          state_d = S_HOLD;
          ph_d    = HOLD_LD;
          // The read byte is captured on the edge ending the strobe.
          if (!write_q) begin
            rd_data_d  = usb_din;
            rd_valid_d = 1'b1;
          end
        end else begin
          ph_d = ph_q - PCW'(1);
        end
      end
      S_HOLD: begin
        if (ph_q != '0) begin
          ph_d = ph_q - PCW'(1);
        end else if (bcnt_q == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          bcnt_d = bcnt_q + pBYTECNT_SIZE'(1);
          addr_d = addr_q + pADDR_WIDTH'(1);
`ifdef USB_REG_MASTER_TIMEOUT_EN
          tmo_d  = '0;
`endif
          if (write_q) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_SETUP;
            ph_d    = SETUP_LD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      bcnt_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef USB_REG_MASTER_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
`ifdef USB_REG_MASTER_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef USB_REG_MASTER_TIMEOUT_EN
  assign err = err_q;
`else
  // Without the timeout, err never fires and pTIMEOUT has no effect.
  logic unused_tmo;
  assign unused_tmo = err_d | (pTIMEOUT != 0);
  assign err        = 1'b0;
`endif

  // Bus controls decode from state so reset releases them without a clock.
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WDATA);
  assign usb_cen   = (state_q == S_IDLE);
  assign usb_isout = write_q & busy;
  assign usb_rdn   = !((state_q == S_STROBE) && !write_q);
  assign usb_wrn   = !((state_q == S_STROBE) && write_q);
  assign usb_addr  = addr_q;
  assign usb_dout  = dout_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_usb_reg_master.sv
// tb_usb_reg_master: randomized and directed bursts against a cycle-timeline
// model. Each command is expanded into the per-cycle bus picture implied by the
// phase lengths; a compare process checks every cycle against it.
module tb_usb_reg_master;
  localparam int AW = 21, BC = 7, TSU = 1, TST = 2, THO = 1, TMO = 8;

  logic usb_clk = 1'b0, resetn = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BC-1:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0;
  logic cmd_ready, wr_ready, rd_valid, busy, done, err, usb_isout, usb_cen, usb_rdn, usb_wrn;
  logic [7:0] rd_data, usb_dout, usb_din;
  logic [AW-1:0] usb_addr;

  logic [7:0] mem [256];
  assign usb_din = mem[usb_addr[7:0]];

  always #5 usb_clk = ~usb_clk;

  usb_reg_master #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pSETUP(TSU), .pSTROBE(TST),
                   .pHOLD(THO), .pTIMEOUT(TMO)) dut (
    .usb_clk(usb_clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err), .usb_addr(usb_addr), .usb_dout(usb_dout),
    .usb_din(usb_din), .usb_isout(usb_isout), .usb_cen(usb_cen), .usb_rdn(usb_rdn),
    .usb_wrn(usb_wrn));

  typedef struct packed {
    logic busy, cen, rdn, wrn, isout, wr_ready, cmd_ready, rd_valid, done, err, dchk;
    logic [AW-1:0] addr;
    logic [7:0] dout, rdd;
  } exp_t;

  exp_t e_cur = '0;
  bit   chk_en = 1'b0;
  bit   pend_done = 1'b0, pend_err = 1'b0;
  int   nchk = 0, nerr = 0;
  int   stall [128];
  logic [7:0] wdat [128];

  // Observation counters for literal expectations.
  int cyc_n = 0, rdn_low = 0, wrn_low = 0, rdv_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int rdv_cyc = 0, done_cyc = 0, err_cyc = 0, acc_cyc = 0;
  logic [AW-1:0] last_w_addr = '0;
  logic [7:0] last_w_dout = '0, last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model timeline.
  always @(negedge usb_clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_cur.busy));
      chk("usb_cen", 32'(usb_cen), 32'(e_cur.cen));
      chk("usb_rdn", 32'(usb_rdn), 32'(e_cur.rdn));
      chk("usb_wrn", 32'(usb_wrn), 32'(e_cur.wrn));
      chk("usb_isout", 32'(usb_isout), 32'(e_cur.isout));
      chk("wr_ready", 32'(wr_ready), 32'(e_cur.wr_ready));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_cur.cmd_ready));
      chk("rd_valid", 32'(rd_valid), 32'(e_cur.rd_valid));
      chk("done", 32'(done), 32'(e_cur.done));
      chk("err", 32'(err), 32'(e_cur.err));
      if (!e_cur.cen) chk("usb_addr", 32'(usb_addr), 32'(e_cur.addr));
      if (e_cur.dchk) chk("usb_dout", 32'(usb_dout), 32'(e_cur.dout));
      if (e_cur.rd_valid) chk("rd_data", 32'(rd_data), 32'(e_cur.rdd));
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge usb_clk) begin
    cyc_n++;
    if (!usb_rdn) rdn_low++;
    if (!usb_wrn) begin
      wrn_low++;
      last_w_addr = usb_addr;
      last_w_dout = usb_dout;
    end
    if (rd_valid) begin rdv_cnt++; rdv_cyc = cyc_n; last_rd = rd_data; end
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    if (err) begin err_cnt++; err_cyc = cyc_n; end
    if (busy) busy_cnt++;
  end

  function automatic exp_t idle_rec();
    exp_t e = '0;
    e.cen = 1'b1; e.rdn = 1'b1; e.wrn = 1'b1; e.cmd_ready = 1'b1;
    e.done = pend_done; e.err = pend_err;
    return e;
  endfunction

  // One clock cycle: publish expectation, drive inputs, advance past the edge.
  task automatic cyc(input exp_t e, input logic cv, input logic wv, input logic [7:0] wd);
    e_cur = e;
    if (e.busy) begin
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_len   = BC'($urandom);
    end else begin
      cmd_valid = cv;
    end
    wr_valid = wv;
    wr_data  = wd;
    @(posedge usb_clk); #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = idle_rec();
      pend_done = 1'b0; pend_err = 1'b0;
      cyc(e, 1'b0, 1'b0, 8'($urandom));
    end
  endtask

  // Expand one command into its expected cycle timeline and play it.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a0, input int len, input bit abort);
    exp_t e;
    logic [AW-1:0] a;
    e = idle_rec();
    pend_done = 1'b0; pend_err = 1'b0;
    cmd_write = w; cmd_addr = a0; cmd_len = BC'(len);
    acc_cyc = cyc_n + 1;
    cyc(e, 1'b1, 1'b0, 8'h00);
    for (int b = 0; b <= len; b++) begin
      a = a0 + AW'(b);
      e = '0;
      e.busy = 1'b1; e.rdn = 1'b1; e.wrn = 1'b1; e.isout = w; e.addr = a;
      if (w) begin
        e.wr_ready = 1'b1;
        for (int s = 0; s < stall[b]; s++) cyc(e, 1'b0, 1'b0, 8'($urandom));
        cyc(e, 1'b0, 1'b1, wdat[b]);
        e.wr_ready = 1'b0; e.dchk = 1'b1; e.dout = wdat[b];
      end
      for (int i = 0; i < TSU; i++) cyc(e, 1'b0, 1'b0, 8'($urandom));
      e.rdn = w; e.wrn = !w;
      for (int i = 0; i < TST; i++) begin
        if (abort) begin
          chk_en = 1'b0;
          cmd_valid = 1'b0; wr_valid = 1'b0;
          chk("pre_rst_wrn", 32'(usb_wrn), 32'(0));
          #2; resetn = 1'b0; #1;
          chk("rst_wrn", 32'(usb_wrn), 32'(1));
          chk("rst_cen", 32'(usb_cen), 32'(1));
          chk("rst_isout", 32'(usb_isout), 32'(0));
          chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
          chk("rst_busy", 32'(busy), 32'(0));
          return;
        end
        cyc(e, 1'b0, 1'b0, 8'($urandom));
      end
      e.rdn = 1'b1; e.wrn = 1'b1;
      for (int i = 0; i < THO; i++) begin
        e.rd_valid = !w && (i == 0);
        e.rdd = mem[a[7:0]];
        cyc(e, 1'b0, 1'b0, 8'($urandom));
      end
    end
    pend_done = 1'b1;
  endtask

  int s_rdn, s_wrn, s_rdv, s_done, s_err, s_busy;
  task automatic snap();
    s_rdn = rdn_low; s_wrn = wrn_low; s_rdv = rdv_cnt;
    s_done = done_cnt; s_err = err_cnt; s_busy = busy_cnt;
  endtask

  initial begin
    logic w;
    logic [AW-1:0] a;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;
    for (int i = 0; i < 128; i++) begin stall[i] = 0; wdat[i] = 8'($urandom); end

    #1 resetn = 1'b0;
    #2;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("reset_strobes", 32'({usb_cen, usb_rdn, usb_wrn}), 32'(3'b111));
    chk("reset_isout", 32'(usb_isout), 32'(0));
    chk("reset_addr", 32'(usb_addr), 32'(0));
    chk("reset_dout", 32'(usb_dout), 32'(0));
    chk("reset_rd_data", 32'(rd_data), 32'(0));
    chk("reset_pulses", 32'({rd_valid, done, err, busy, wr_ready}), 32'(0));
    @(posedge usb_clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Single read at 0x10: latency and strobe width pinned by literals.
    snap();
    run_cmd(1'b0, 21'h000010, 0, 1'b0);
    idle(1);
    chk("rd_latency", 32'(rdv_cyc - acc_cyc), 32'(4));
    chk("rd_done_at", 32'(done_cyc - acc_cyc), 32'(5));
    chk("rd_rdn_cycles", 32'(rdn_low - s_rdn), 32'(2));
    chk("rd_byte", 32'(last_rd), 32'(8'hA5));

    // Single write at 0x20 with data already valid.
    snap();
    stall[0] = 0; wdat[0] = 8'h3C;
    run_cmd(1'b1, 21'h000020, 0, 1'b0);
    idle(1);
    chk("wr_wrn_cycles", 32'(wrn_low - s_wrn), 32'(2));
    chk("wr_no_rdn", 32'(rdn_low - s_rdn), 32'(0));
    chk("wr_dout", 32'(last_w_dout), 32'(8'h3C));
    chk("wr_addr", 32'(last_w_addr), 32'(21'h000020));

    // Four-byte read burst at 0x100.
    snap();
    run_cmd(1'b0, 21'h000100, 3, 1'b0);
    idle(1);
    chk("burst_rd_valids", 32'(rdv_cnt - s_rdv), 32'(4));
    chk("burst_done_once", 32'(done_cnt - s_done), 32'(1));

    // Two-byte write wrapping at the top of the address space, 5-cycle stall.
    snap();
    stall[0] = 0; stall[1] = 5; wdat[0] = 8'h11; wdat[1] = 8'h22;
    run_cmd(1'b1, 21'h1FFFFF, 1, 1'b0);
    idle(1);
    chk("wrap_addr", 32'(last_w_addr), 32'(0));
    chk("wrap_dout", 32'(last_w_dout), 32'(8'h22));
    chk("wrap_wrn_cycles", 32'(wrn_low - s_wrn), 32'(4));
    chk("wrap_busy_cycles", 32'(busy_cnt - s_busy), 32'(15));

    // Reset during a write strobe, then a clean read.
    stall[0] = 0; wdat[0] = 8'h5A;
    run_cmd(1'b1, 21'h000040, 0, 1'b1);
    repeat (2) @(posedge usb_clk);
    #1;
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    resetn = 1'b1;
    pend_done = 1'b0; pend_err = 1'b0;
    chk_en = 1'b1;
    idle(1);
    snap();
    run_cmd(1'b0, 21'h000010, 0, 1'b0);
    idle(1);
    chk("post_rst_read", 32'(rdv_cnt - s_rdv), 32'(1));

`ifdef USB_REG_MASTER_TIMEOUT_EN
    // Write whose data never arrives: abandoned after TMO cycles.
    begin
      exp_t e;
      snap();
      e = idle_rec();
      pend_done = 1'b0; pend_err = 1'b0;
      cmd_write = 1'b1; cmd_addr = 21'h000050; cmd_len = '0;
      cyc(e, 1'b1, 1'b0, 8'h00);
      e = '0;
      e.busy = 1'b1; e.rdn = 1'b1; e.wrn = 1'b1; e.isout = 1'b1; e.wr_ready = 1'b1;
      e.addr = 21'h000050;
      repeat (TMO) cyc(e, 1'b0, 1'b0, 8'($urandom));
      pend_done = 1'b1; pend_err = 1'b1;
      idle(1);
      chk("tmo_err_once", 32'(err_cnt - s_err), 32'(1));
      chk("tmo_err_with_done", 32'(err_cyc), 32'(done_cyc));
    end
`else
    // Without the timeout a long write stall just keeps the burst busy.
    snap();
    stall[0] = 20; wdat[0] = 8'h77;
    run_cmd(1'b1, 21'h000050, 0, 1'b0);
    idle(1);
    chk("stall_busy_cycles", 32'(busy_cnt - s_busy), 32'(25));
    chk("stall_no_err", 32'(err_cnt - s_err), 32'(0));
`endif

    // Random bursts, some back-to-back, some near the address wrap.
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom);
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = '1 - AW'($urandom_range(0, 3));
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin
        stall[i] = $urandom_range(0, 3);
        wdat[i]  = 8'($urandom);
      end
      run_cmd(w, a, len, 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
